// File: rtl/sm83_regfile_if.sv
// sm83_regfile_if: read/write/IDU bundle between the SM83 core (master) and its register file (slave).
interface sm83_regfile_if;
  logic [2:0]  rd_a_sel, rd_b_sel, wr_sel, pair_rd_sel, pair_wr_sel, idu_sel;
  logic [7:0]  rd_a_data, rd_b_data, wr_data;
  logic        wr_en, pair_we, idu_en, idu_dec;
  logic [3:0]  flags_we, flags_in, flags_out;
  logic [15:0] pair_rd_data, pair_wr_data, pc_out, sp_out;
  modport master (
    output rd_a_sel, rd_b_sel, wr_en, wr_sel, wr_data, flags_we, flags_in,
           pair_rd_sel, pair_we, pair_wr_sel, pair_wr_data, idu_en, idu_dec, idu_sel,
    input  rd_a_data, rd_b_data, flags_out, pair_rd_data, pc_out, sp_out
  );
  modport slave (
    input  rd_a_sel, rd_b_sel, wr_en, wr_sel, wr_data, flags_we, flags_in,
           pair_rd_sel, pair_we, pair_wr_sel, pair_wr_data, idu_en, idu_dec, idu_sel,
    output rd_a_data, rd_b_data, flags_out, pair_rd_data, pc_out, sp_out
  );
endinterface

// File: rtl/sm83_regfile.sv
// sm83_regfile: SM83 architectural registers with 8/16-bit ports and IDU.
// Define REGFILE_BYPASS_EN to forward next-state values to all outputs in the same cycle.
module sm83_regfile #(
  parameter logic [15:0] SP_RST = 16'hFFFE,
  parameter logic [15:0] PC_RST = 16'h0000
) (
  input logic           clk,
  input logic           rst,
  sm83_regfile_if.slave bus
);
  localparam int AF = 4;
  // pair slots follow the r16 encoding: BC, DE, HL, SP, AF, PC
  logic [15:0] r_pair [6];
  logic [15:0] w_nxt  [6];
  logic [15:0] w_view [6];
  // sources are applied lowest priority first so later ones win per bit
  always_comb begin
    for (int p = 0; p < 6; p++) begin
      w_nxt[p] = r_pair[p];
      if (bus.idu_en && bus.idu_sel == 3'(p) && p != AF)
        w_nxt[p] = r_pair[p] + (bus.idu_dec ? 16'hFFFF : 16'h0001);
      if (bus.pair_we && bus.pair_wr_sel == 3'(p))
        w_nxt[p] = bus.pair_wr_data;
      if (bus.wr_en && p < 3 && bus.wr_sel[2:1] == 2'(p)) begin
        if (bus.wr_sel[0]) w_nxt[p][7:0] = bus.wr_data;
        else w_nxt[p][15:8] = bus.wr_data;
      end
      if (p == AF) begin
        if (bus.wr_en && bus.wr_sel == 3'd7) w_nxt[p][15:8] = bus.wr_data;
        w_nxt[p][7:0] = {(bus.flags_we & bus.flags_in) | (~bus.flags_we & w_nxt[p][7:4]), 4'h0};
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) for (int p = 0; p < 6; p++) r_pair[p] <= p == 3 ? SP_RST : p == 5 ? PC_RST : 16'h0000;
    else r_pair <= w_nxt;
  end
`ifdef REGFILE_BYPASS_EN
  assign w_view = w_nxt;
`else
  assign w_view = r_pair;
`endif
  always_comb begin
    bus.rd_a_data = bus.rd_a_sel == 3'd7 ? w_view[AF][15:8] : bus.rd_a_sel == 3'd6 ? 8'h00 :
                    bus.rd_a_sel[0] ? w_view[{1'b0, bus.rd_a_sel[2:1]}][7:0] : w_view[{1'b0, bus.rd_a_sel[2:1]}][15:8];
    bus.rd_b_data = bus.rd_b_sel == 3'd7 ? w_view[AF][15:8] : bus.rd_b_sel == 3'd6 ? 8'h00 :
                    bus.rd_b_sel[0] ? w_view[{1'b0, bus.rd_b_sel[2:1]}][7:0] : w_view[{1'b0, bus.rd_b_sel[2:1]}][15:8];
    bus.pair_rd_data = bus.pair_rd_sel < 3'd6 ? w_view[bus.pair_rd_sel] : 16'h0000;
    bus.flags_out = w_view[AF][7:4];
    bus.sp_out = w_view[3];
    bus.pc_out = w_view[5];
  end
endmodule

// File: tb/tb_sm83_regfile.sv
// tb_sm83_regfile: directed and random checks of sm83_regfile against a named-register model.
module tb_sm83_regfile;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  sm83_regfile_if bus();
  sm83_regfile dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // model: byte registers indexed by r8 code, slot 6 holds F; SP/PC separate
  logic [7:0]  m_r8 [8];
  logic [15:0] m_sp, m_pc;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r8[i] = 8'h00;
    m_sp = 16'hFFFE;
    m_pc = 16'h0000;
  endtask
  function automatic logic [15:0] pair_get(input logic [2:0] s);
    case (s)
      3'd0: return {m_r8[0], m_r8[1]};
      3'd1: return {m_r8[2], m_r8[3]};
      3'd2: return {m_r8[4], m_r8[5]};
      3'd3: return m_sp;
      3'd4: return {m_r8[7], m_r8[6]};
      3'd5: return m_pc;
      default: return 16'h0000;
    endcase
  endfunction
  task automatic pair_set(input logic [2:0] s, input logic [15:0] v);
    case (s)
      3'd0: {m_r8[0], m_r8[1]} = v;
      3'd1: {m_r8[2], m_r8[3]} = v;
      3'd2: {m_r8[4], m_r8[5]} = v;
      3'd3: m_sp = v;
      3'd4: begin m_r8[7] = v[15:8]; m_r8[6] = {v[7:4], 4'h0}; end
      3'd5: m_pc = v;
      default: ;
    endcase
  endtask
  function automatic logic [7:0] r8_get(input logic [2:0] s);
    return s == 3'd6 ? 8'h00 : m_r8[s];
  endfunction
  task automatic model_step();
    logic [15:0] v;
    if (bus.idu_en && bus.idu_sel != 3'd4 && bus.idu_sel < 3'd6) begin
      v = pair_get(bus.idu_sel);
      v = bus.idu_dec ? 16'(v - 16'd1) : 16'(v + 16'd1);
      pair_set(bus.idu_sel, v);
    end
    if (bus.pair_we) pair_set(bus.pair_wr_sel, bus.pair_wr_data);
    if (bus.wr_en && bus.wr_sel != 3'd6) m_r8[bus.wr_sel] = bus.wr_data;
    for (int i = 0; i < 4; i++) if (bus.flags_we[i]) m_r8[6][4+i] = bus.flags_in[i];
  endtask
  task automatic check_all();
    chk("rd_a", {8'h00, bus.rd_a_data}, {8'h00, r8_get(bus.rd_a_sel)});
    chk("rd_b", {8'h00, bus.rd_b_data}, {8'h00, r8_get(bus.rd_b_sel)});
    chk("flags", {12'h000, bus.flags_out}, {12'h000, m_r8[6][7:4]});
    chk("pair_rd", bus.pair_rd_data, pair_get(bus.pair_rd_sel));
    chk("pc", bus.pc_out, m_pc);
    chk("sp", bus.sp_out, m_sp);
  endtask
  task automatic do_cycle();
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    model_step();
    check_all();
    @(posedge clk);
`else
    check_all();
    @(posedge clk);
    model_step();
`endif
    #1;
  endtask
  task automatic idle();
    bus.wr_en = 0; bus.pair_we = 0; bus.idu_en = 0; bus.idu_dec = 0; bus.flags_we = 4'h0;
    bus.wr_sel = 3'd0; bus.wr_data = 8'h00; bus.flags_in = 4'h0;
    bus.pair_wr_sel = 3'd0; bus.pair_wr_data = 16'h0000; bus.idu_sel = 3'd0;
  endtask
  initial begin
    idle();
    bus.rd_a_sel = 3'd7; bus.rd_b_sel = 3'd0; bus.pair_rd_sel = 3'd2;
    model_reset();
    @(posedge clk); #1 rst = 0;
    #1;
    chk("rst_a", {8'h00, bus.rd_a_data}, 16'h0000);
    chk("rst_b", {8'h00, bus.rd_b_data}, 16'h0000);
    chk("rst_flags", {12'h000, bus.flags_out}, 16'h0000);
    chk("rst_pc", bus.pc_out, 16'h0000);
    chk("rst_sp", bus.sp_out, 16'hFFFE);
    chk("rst_pair", bus.pair_rd_data, 16'h0000);
    bus.wr_en = 1; bus.wr_sel = 3'd7; bus.wr_data = 8'h3C;
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    chk("wr_a_same", {8'h00, bus.rd_a_data}, 16'h003C);
`else
    chk("wr_a_same", {8'h00, bus.rd_a_data}, 16'h0000);
`endif
    @(posedge clk); model_step(); #1;
    idle();
    #1 chk("wr_a_next", {8'h00, bus.rd_a_data}, 16'h003C);
    bus.rd_b_sel = 3'd6;
    #1 chk("sel6", {8'h00, bus.rd_b_data}, 16'h0000);
    bus.flags_we = 4'b1001; bus.flags_in = 4'b1111;
    do_cycle(); idle();
    chk("flag_mask", {12'h000, bus.flags_out}, 16'h0009);
    bus.pair_we = 1; bus.pair_wr_sel = 3'd4; bus.pair_wr_data = 16'h12FF;
    do_cycle(); idle();
    bus.pair_rd_sel = 3'd4;
    #1 chk("af_write", bus.pair_rd_data, 16'h12F0);
    bus.pair_we = 1; bus.pair_wr_sel = 3'd2; bus.pair_wr_data = 16'hFFFF;
    do_cycle(); idle();
    bus.idu_en = 1; bus.idu_sel = 3'd2;
    do_cycle(); idle();
    bus.pair_rd_sel = 3'd2;
    #1 chk("hl_wrap", bus.pair_rd_data, 16'h0000);
    chk("hl_wrap_flags", {12'h000, bus.flags_out}, 16'h000F);
    bus.pair_we = 1; bus.pair_wr_sel = 3'd3; bus.pair_wr_data = 16'h0000;
    do_cycle(); idle();
    bus.idu_en = 1; bus.idu_dec = 1; bus.idu_sel = 3'd3;
    do_cycle(); idle();
    chk("sp_wrap", bus.sp_out, 16'hFFFF);
    chk("sp_wrap_flags", {12'h000, bus.flags_out}, 16'h000F);
    bus.idu_en = 1; bus.idu_sel = 3'd4;
    do_cycle(); idle();
    chk("idu_af_ignored", {bus.rd_a_data, bus.flags_out, 4'h0}, 16'h12F0);
    bus.pair_we = 1; bus.pair_wr_sel = 3'd2; bus.pair_wr_data = 16'h10FF;
    do_cycle(); idle();
    bus.idu_en = 1; bus.idu_sel = 3'd2;
    bus.pair_we = 1; bus.pair_wr_sel = 3'd2; bus.pair_wr_data = 16'hABCD;
    bus.wr_en = 1; bus.wr_sel = 3'd5; bus.wr_data = 8'h55;
    do_cycle(); idle();
    bus.pair_rd_sel = 3'd2;
    #1 chk("collision", bus.pair_rd_data, 16'hAB55);
`ifdef REGFILE_BYPASS_EN
    bus.wr_en = 1; bus.wr_sel = 3'd0; bus.wr_data = 8'h7E; bus.rd_a_sel = 3'd0;
    #1 chk("bypass_b", {8'h00, bus.rd_a_data}, 16'h007E);
    do_cycle(); idle();
`endif
    for (int n = 0; n < 400; n++) begin
      bus.rd_a_sel = 3'($urandom_range(0, 7));
      bus.rd_b_sel = 3'($urandom_range(0, 7));
      bus.pair_rd_sel = 3'($urandom_range(0, 7));
      bus.wr_en = ($urandom_range(0, 2) == 0);
      bus.wr_sel = 3'($urandom_range(0, 7));
      bus.wr_data = 8'($urandom());
      bus.flags_we = 4'($urandom());
      bus.flags_in = 4'($urandom());
      bus.pair_we = ($urandom_range(0, 2) == 0);
      bus.pair_wr_sel = 3'($urandom_range(0, 7));
      bus.pair_wr_data = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom());
      bus.idu_en = ($urandom_range(0, 1) == 0);
      bus.idu_dec = 1'($urandom());
      bus.idu_sel = 3'($urandom_range(0, 7));
      do_cycle();
    end
    idle();
    bus.rd_a_sel = 3'd7; bus.rd_b_sel = 3'd5; bus.pair_rd_sel = 3'd5;
    bus.wr_en = 1; bus.wr_sel = 3'd7; bus.wr_data = 8'h99;
    bus.pair_we = 1; bus.pair_wr_sel = 3'd3; bus.pair_wr_data = 16'h1234;
    bus.flags_we = 4'hF; bus.flags_in = 4'hF;
    #2 rst = 1;
    #1;
    chk("async_rst_a", {8'h00, bus.rd_a_data}, 16'h0000);
    chk("async_rst_sp", bus.sp_out, 16'hFFFE);
    @(posedge clk); #1;
    chk("rst_hold_a", {8'h00, bus.rd_a_data}, 16'h0000);
    chk("rst_hold_flags", {12'h000, bus.flags_out}, 16'h0000);
    chk("rst_hold_l", {8'h00, bus.rd_b_data}, 16'h0000);
    chk("rst_hold_pc", bus.pair_rd_data, 16'h0000);
    idle();
    rst = 0;
    model_reset();
    do_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
